// File: rtl/sec_timer_multi.sv
// Multi-channel seconds timer: CHANNELS independent down-counters of whole seconds derived from
// one CLK_HZ clock, each with one-shot/periodic mode, restart, abort and a one-cycle done pulse.
module sec_timer_multi #(
  parameter int unsigned CLK_HZ   = 10000,
  parameter int unsigned SEC_W    = 7,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       startCounting,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*SEC_W-1:0] secondsToCount,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       timeFinished,
  output logic [CHANNELS*SEC_W-1:0] secondsLeft
);

  localparam int unsigned CycW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CycW-1:0] CycMax = CycW'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SecOne = SEC_W'(1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    logic [CycW-1:0]  cycCnt;
    logic [SEC_W-1:0] secCnt;
    logic [SEC_W-1:0] loadVal;
    logic [SEC_W-1:0] loadIn;
    logic             modePer;
    logic [0:0]       state;
    logic             pulse;

    assign loadIn = secondsToCount[i*SEC_W +: SEC_W];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= StIdle;
        cycCnt  <= '0;
        secCnt  <= '0;
        loadVal <= '0;
        modePer <= 1'b0;
        pulse   <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (abort[i]) begin
          state   <= StIdle;
          cycCnt  <= '0;
          secCnt  <= '0;
          loadVal <= '0;
          modePer <= 1'b0;
        end else if (startCounting[i]) begin
          // Periodic with a zero load would pulse every cycle; it degrades to one-shot.
          loadVal <= loadIn;
          modePer <= periodic[i] && (loadIn != '0);
          cycCnt  <= '0;
          secCnt  <= loadIn;
          state   <= StRun;
        end else if (state == StRun) begin
          if (secCnt == '0) begin
            pulse  <= 1'b1;
            state  <= StIdle;
            cycCnt <= '0;
          end else if (cycCnt < CycMax) begin
            cycCnt <= cycCnt + 1'b1;
          end else begin
            cycCnt <= '0;
            if (secCnt == SecOne) begin
              pulse <= 1'b1;
              if (modePer) begin
                secCnt <= loadVal;
              end else begin
                secCnt <= '0;
                state  <= StIdle;
              end
            end else begin
              secCnt <= secCnt - 1'b1;
            end
          end
        end
      end
    end

    assign busy[i]                        = (state == StRun);
    assign timeFinished[i]                = pulse;
    assign secondsLeft[i*SEC_W +: SEC_W]  = secCnt;
  end

endmodule

// File: tb/tb_sec_timer_multi.sv
// Directed bench for sec_timer_multi with CLK_HZ=10, SEC_W=7, CHANNELS=2.
module tb_sec_timer_multi;

  localparam int unsigned CLK_HZ   = 10;
  localparam int unsigned SEC_W    = 7;
  localparam int unsigned CHANNELS = 2;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS-1:0]       startCounting;
  logic [CHANNELS-1:0]       abort;
  logic [CHANNELS-1:0]       periodic;
  logic [CHANNELS*SEC_W-1:0] secondsToCount;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       timeFinished;
  logic [CHANNELS*SEC_W-1:0] secondsLeft;

  int nChecks = 0;
  int nFail   = 0;

  sec_timer_multi #(
    .CLK_HZ  (CLK_HZ),
    .SEC_W   (SEC_W),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startCounting (startCounting),
    .abort         (abort),
    .periodic      (periodic),
    .secondsToCount(secondsToCount),
    .busy          (busy),
    .timeFinished  (timeFinished),
    .secondsLeft   (secondsLeft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sl(input int ch);
    return 32'(secondsLeft[ch*SEC_W +: SEC_W]);
  endfunction

  // Leaves the bench 1 time unit after the start edge E0.
  task automatic startCh(input int ch, input int n, input logic per);
    secondsToCount[ch*SEC_W +: SEC_W] = SEC_W'(n);
    periodic[ch]      = per;
    startCounting[ch] = 1'b1;
    tick(1);
    startCounting[ch] = 1'b0;
  endtask

  task automatic abortCh(input int ch);
    abort[ch] = 1'b1;
    tick(1);
    abort[ch] = 1'b0;
  endtask

  initial begin
    int pulses;
    reset          = 1'b1;
    startCounting  = '0;
    abort          = '0;
    periodic       = '0;
    secondsToCount = '0;
    tick(2);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tf", 32'(timeFinished), 32'd0);
    check("reset secondsLeft", 32'(secondsLeft), 32'd0);
    reset = 1'b0;
    tick(2);

    // One-shot, N=3 on ch0
    startCh(0, 3, 1'b0);
    check("os busy e0", 32'(busy[0]), 32'd1);
    check("os sl e0", sl(0), 32'd3);
    check("os tf e0", 32'(timeFinished[0]), 32'd0);
    tick(9);
    check("os sl e9", sl(0), 32'd3);
    tick(1);
    check("os sl e10", sl(0), 32'd2);
    tick(10);
    check("os sl e20", sl(0), 32'd1);
    tick(9);
    check("os tf e29", 32'(timeFinished[0]), 32'd0);
    check("os busy e29", 32'(busy[0]), 32'd1);
    tick(1);
    check("os tf e30", 32'(timeFinished[0]), 32'd1);
    check("os busy e30", 32'(busy[0]), 32'd0);
    check("os sl e30", sl(0), 32'd0);
    tick(1);
    check("os tf e31", 32'(timeFinished[0]), 32'd0);
    tick(3);

    // Periodic, N=2 on ch1; input changes mid-run must be ignored
    startCh(1, 2, 1'b1);
    secondsToCount[SEC_W +: SEC_W] = 7'd5;
    periodic[1] = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      check($sformatf("per tf e%0d", k), 32'(timeFinished[1]), (k % 20 == 0) ? 32'd1 : 32'd0);
      check($sformatf("per busy e%0d", k), 32'(busy[1]), 32'd1);
    end
    abortCh(1);
    check("per abort busy", 32'(busy[1]), 32'd0);
    check("per abort sl", sl(1), 32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (timeFinished[1] || busy[1]) pulses++;
    end
    check("per after abort activity", 32'(pulses), 32'd0);

    // Restart: N=5 at edge 0, N=1 at edge 25 -> single pulse after edge 35
    startCh(0, 5, 1'b0);
    tick(24);
    startCh(0, 1, 1'b0);
    check("rst sl e25", sl(0), 32'd1);
    check("rst busy e25", 32'(busy[0]), 32'd1);
    for (int k = 26; k <= 55; k++) begin
      tick(1);
      check($sformatf("restart tf e%0d", k), 32'(timeFinished[0]), (k == 35) ? 32'd1 : 32'd0);
    end
    check("restart busy end", 32'(busy[0]), 32'd0);

    // Abort on the expiry edge suppresses the pulse
    startCh(0, 1, 1'b0);
    tick(9);
    abortCh(0);
    check("abort-expiry tf", 32'(timeFinished[0]), 32'd0);
    check("abort-expiry busy", 32'(busy[0]), 32'd0);
    tick(1);
    check("abort-expiry tf+1", 32'(timeFinished[0]), 32'd0);

    // N=0 one-shot
    startCh(0, 0, 1'b0);
    check("n0 busy e0", 32'(busy[0]), 32'd1);
    check("n0 sl e0", sl(0), 32'd0);
    check("n0 tf e0", 32'(timeFinished[0]), 32'd0);
    tick(1);
    check("n0 tf e1", 32'(timeFinished[0]), 32'd1);
    check("n0 busy e1", 32'(busy[0]), 32'd0);
    tick(1);
    check("n0 tf e2", 32'(timeFinished[0]), 32'd0);

    // N=0 periodic behaves as one-shot
    startCh(0, 0, 1'b1);
    tick(1);
    check("n0p tf e1", 32'(timeFinished[0]), 32'd1);
    check("n0p busy e1", 32'(busy[0]), 32'd0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      if (timeFinished[0]) pulses++;
    end
    check("n0p extra pulses", 32'(pulses), 32'd0);

    // N=127 maximum delay on ch1
    startCh(1, 127, 1'b0);
    check("max sl e0", sl(1), 32'd127);
    tick(1269);
    check("max tf e1269", 32'(timeFinished[1]), 32'd0);
    check("max busy e1269", 32'(busy[1]), 32'd1);
    check("max sl e1269", sl(1), 32'd1);
    tick(1);
    check("max tf e1270", 32'(timeFinished[1]), 32'd1);
    check("max busy e1270", 32'(busy[1]), 32'd0);
    check("max sl e1270", sl(1), 32'd0);
    tick(1);

    // Start and abort on the same edge: abort wins
    secondsToCount[0 +: SEC_W] = 7'd4;
    startCounting[0] = 1'b1;
    abort[0]         = 1'b1;
    tick(1);
    startCounting[0] = 1'b0;
    abort[0]         = 1'b0;
    check("start+abort busy", 32'(busy[0]), 32'd0);
    check("start+abort sl", sl(0), 32'd0);

    // Asynchronous reset mid-count at edge 14.5
    startCh(0, 3, 1'b0);
    tick(14);
    check("areset pre sl", sl(0), 32'd2);
    #4;
    reset = 1'b1;
    #1;
    check("areset busy", 32'(busy), 32'd0);
    check("areset tf", 32'(timeFinished), 32'd0);
    check("areset sl", 32'(secondsLeft), 32'd0);
    tick(2);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (timeFinished[0] || busy[0]) pulses++;
    end
    check("areset no resume", 32'(pulses), 32'd0);

    // Independence: ch0 N=1, ch1 N=2 started together
    secondsToCount = {7'd2, 7'd1};
    periodic       = 2'b00;
    startCounting  = 2'b11;
    tick(1);
    startCounting  = 2'b00;
    check("ind busy e0", 32'(busy), 32'd3);
    tick(10);
    check("ind tf e10", 32'(timeFinished), 32'd1);
    check("ind busy e10", 32'(busy), 32'd2);
    tick(10);
    check("ind tf e20", 32'(timeFinished), 32'd2);
    check("ind busy e20", 32'(busy), 32'd0);
    tick(2);

    // Abort ch1 mid-count, ch0 unaffected
    startCounting = 2'b11;
    tick(1);
    startCounting = 2'b00;
    tick(4);
    abortCh(1);
    check("ind abort busy", 32'(busy), 32'd1);
    check("ind abort sl0", sl(0), 32'd1);
    tick(5);
    check("ind abort tf e10", 32'(timeFinished), 32'd1);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (timeFinished[1]) pulses++;
    end
    check("ind abort ch1 pulses", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
